// File: rtl/note_event_recorder_pkg.sv
// Shared types and helpers for the note event recorder: FSM states, entry field layout
// and derived width calculation.
package note_event_recorder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REC,
        CLOSE,
        PLAY_RD,
        PLAY_OUT,
        DONE
    } recState_t;

    // Entry packing {key, start, end}: field index counts TIME_W slices up from the LSB.
    localparam int unsigned FIELD_END   = 0;
    localparam int unsigned FIELD_START = 1;
    localparam int unsigned FIELD_KEY   = 2;

    function automatic int unsigned idWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned fieldLsb(input int unsigned field, input int unsigned timeW);
        return field * timeW;
    endfunction

endpackage

// File: rtl/note_store_ram.sv
// Simple dual-port note store: one write port with whole-entry or end-field-only write,
// one read port with a single registered read stage.
module note_store_ram #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned KEY_W  = 5,
    parameter int unsigned TIME_W = 29
) (
    input  logic                        clk,
    input  logic                        wrAll,
    input  logic                        wrEnd,
    input  logic [ADDR_W-1:0]           wrAddr,
    input  logic [KEY_W+2*TIME_W-1:0]   wrEntry,
    input  logic [TIME_W-1:0]           wrEndTime,
    input  logic                        rdEn,
    input  logic [ADDR_W-1:0]           rdAddr,
    output logic [KEY_W+2*TIME_W-1:0]   rdData
);

    logic [KEY_W+2*TIME_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrAll) begin
            mem[wrAddr] <= wrEntry;
        end else if (wrEnd) begin
            mem[wrAddr][TIME_W-1:0] <= wrEndTime;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/note_event_recorder.sv
// Records timestamped key press/release events into a note store and streams them out.
// Optional macro NOTE_REC_WINDOW_FILTER_EN: playback skips notes outside [view_lo, view_hi].
module note_event_recorder
    import note_event_recorder_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 24,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned TIME_W   = 29,
    localparam int unsigned KEY_W   = idWidth(NUM_KEYS),
    localparam int unsigned ADDR_W  = idWidth(DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tick_us,
    input  logic                record_en,
    input  logic                play_start,
    input  logic [NUM_KEYS-1:0] key_state,
    input  logic [TIME_W-1:0]   view_lo,
    input  logic [TIME_W-1:0]   view_hi,
    output logic                note_valid,
    input  logic                note_ready,
    output logic [KEY_W-1:0]    note_key,
    output logic [TIME_W-1:0]   note_start,
    output logic [TIME_W-1:0]   note_end,
    output logic                frame_done,
    output logic [ADDR_W:0]     note_count,
    output logic                overflow,
    output logic [TIME_W-1:0]   now_time
);

    localparam int unsigned ENTRY_W = KEY_W + 2 * TIME_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    recState_t state;
    logic [TIME_W-1:0]   timer;
    logic [ADDR_W:0]     count, rdPtr;
    logic [NUM_KEYS-1:0] prevKeys, pendPress, pendRel, openV;
    logic [ADDR_W-1:0]   openSlot [NUM_KEYS];
    logic                overflowR, frameDoneR;

    logic [NUM_KEYS-1:0] curPress, curRel;
    logic                svcAny, closeAny, svcRelease, notFull, inWindow, advance, lastPtr;
    logic [KEY_W-1:0]    svcIdx, closeIdx;
    logic                wrAll, wrEnd, rdEn;
    logic [ADDR_W-1:0]   wrAddr;
    logic [ENTRY_W-1:0]  wrEntry, rdData;
    logic [KEY_W-1:0]    rdKey;
    logic [TIME_W-1:0]   rdStart, rdEnd;

    assign curPress = pendPress | (key_state & ~prevKeys);
    assign curRel   = pendRel | (~key_state & prevKeys);
    assign notFull  = count < DEPTH_C;

    always_comb begin
        svcAny   = 1'b0;
        svcIdx   = '0;
        closeAny = 1'b0;
        closeIdx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!svcAny && (curPress[i] || curRel[i])) begin
                svcAny = 1'b1;
                svcIdx = KEY_W'(i);
            end
            if (!closeAny && openV[i]) begin
                closeAny = 1'b1;
                closeIdx = KEY_W'(i);
            end
        end
    end

    // An open note closes before a re-press; otherwise a pending press goes first.
    assign svcRelease = curRel[svcIdx] && (openV[svcIdx] || !curPress[svcIdx]);

    always_comb begin
        wrAll   = 1'b0;
        wrEnd   = 1'b0;
        wrAddr  = '0;
        wrEntry = {svcIdx, timer, {TIME_W{1'b0}}};
        if (state == REC && record_en && svcAny) begin
            if (svcRelease) begin
                wrEnd  = openV[svcIdx];
                wrAddr = openSlot[svcIdx];
            end else begin
                wrAll  = notFull;
                wrAddr = count[ADDR_W-1:0];
            end
        end else if (state == CLOSE && closeAny) begin
            wrEnd  = 1'b1;
            wrAddr = openSlot[closeIdx];
        end
    end

    assign rdEn = (state == PLAY_RD);

    note_store_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .KEY_W (KEY_W),
        .TIME_W(TIME_W)
    ) u_store (
        .clk      (clk),
        .wrAll    (wrAll),
        .wrEnd    (wrEnd),
        .wrAddr   (wrAddr),
        .wrEntry  (wrEntry),
        .wrEndTime(timer),
        .rdEn     (rdEn),
        .rdAddr   (rdPtr[ADDR_W-1:0]),
        .rdData   (rdData)
    );

    assign rdKey   = rdData[fieldLsb(FIELD_KEY, TIME_W) +: KEY_W];
    assign rdStart = rdData[fieldLsb(FIELD_START, TIME_W) +: TIME_W];
    assign rdEnd   = rdData[fieldLsb(FIELD_END, TIME_W) +: TIME_W];

`ifdef NOTE_REC_WINDOW_FILTER_EN
    logic [TIME_W-1:0] viewLo, viewHi;
    assign inWindow = !((rdEnd < viewLo) || (rdStart > viewHi));
`else
    logic unusedView;
    assign unusedView = ^{view_lo, view_hi};
    assign inWindow   = 1'b1;
`endif

    // The read register already holds the entry steady, so valid decodes straight from state.
    assign note_valid = (state == PLAY_OUT) && inWindow;
    assign note_key   = note_valid ? rdKey : '0;
    assign note_start = note_valid ? rdStart : '0;
    assign note_end   = note_valid ? rdEnd : '0;
    assign advance    = (state == PLAY_OUT) && (!inWindow || note_ready);
    assign lastPtr    = (rdPtr + (ADDR_W + 1)'(1)) == count;

    assign frame_done = frameDoneR;
    assign note_count = count;
    assign overflow   = overflowR;
    assign now_time   = timer;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            timer      <= '0;
            count      <= '0;
            rdPtr      <= '0;
            prevKeys   <= '0;
            pendPress  <= '0;
            pendRel    <= '0;
            openV      <= '0;
            overflowR  <= 1'b0;
            frameDoneR <= 1'b0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                openSlot[i] <= '0;
            end
`ifdef NOTE_REC_WINDOW_FILTER_EN
            viewLo <= '0;
            viewHi <= '0;
`endif
        end else begin
            prevKeys   <= key_state;
            frameDoneR <= 1'b0;
            if (tick_us && (timer != '1)) begin
                timer <= timer + TIME_W'(1);
            end
            case (state)
                IDLE: begin
                    if (record_en) begin
                        state     <= REC;
                        timer     <= '0;
                        count     <= '0;
                        overflowR <= 1'b0;
                        openV     <= '0;
                        pendPress <= '0;
                        pendRel   <= '0;
                    end else if (play_start) begin
                        timer <= '0;
                        rdPtr <= '0;
`ifdef NOTE_REC_WINDOW_FILTER_EN
                        viewLo <= view_lo;
                        viewHi <= view_hi;
`endif
                        if (count != '0) begin
                            state <= PLAY_RD;
                        end else begin
                            state      <= DONE;
                            frameDoneR <= 1'b1;
                        end
                    end
                end
                REC: begin
                    if (!record_en) begin
                        state     <= CLOSE;
                        pendPress <= '0;
                        pendRel   <= '0;
                    end else begin
                        pendPress <= curPress;
                        pendRel   <= curRel;
                        if (svcAny) begin
                            if (svcRelease) begin
                                pendRel[svcIdx] <= 1'b0;
                                openV[svcIdx]   <= 1'b0;
                            end else begin
                                pendPress[svcIdx] <= 1'b0;
                                if (notFull) begin
                                    openV[svcIdx]    <= 1'b1;
                                    openSlot[svcIdx] <= count[ADDR_W-1:0];
                                    count            <= count + (ADDR_W + 1)'(1);
                                end else begin
                                    overflowR <= 1'b1;
                                end
                            end
                        end
                    end
                end
                CLOSE: begin
                    if (closeAny) begin
                        openV[closeIdx] <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                PLAY_RD: state <= PLAY_OUT;
                PLAY_OUT: begin
                    if (advance) begin
                        rdPtr <= rdPtr + (ADDR_W + 1)'(1);
                        if (lastPtr) begin
                            state      <= DONE;
                            frameDoneR <= 1'b1;
                        end else begin
                            state <= PLAY_RD;
                        end
                    end
                end
                DONE: begin
                    rdPtr <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_event_recorder.sv
// Scoreboard bench for note_event_recorder (DEPTH=4, TIME_W=6): stimulus pushes expected
// notes and frame markers, a negedge monitor pops and compares what the DUT streams.
module tb_note_event_recorder;

    localparam int unsigned NK   = 24;
    localparam int unsigned TW   = 6;
    localparam int unsigned TMAX = 63;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          tick_us = 1'b0;
    logic          record_en = 1'b0;
    logic          play_start = 1'b0;
    logic [NK-1:0] key_state = '0;
    logic [TW-1:0] view_lo = '0;
    logic [TW-1:0] view_hi = '0;
    logic          note_valid;
    logic          note_ready = 1'b1;
    logic [4:0]    note_key;
    logic [TW-1:0] note_start, note_end, now_time;
    logic          frame_done, overflow;
    logic [2:0]    note_count;

    note_event_recorder #(.NUM_KEYS(NK), .DEPTH(4), .TIME_W(TW)) dut (
        .clk(clk), .resetn(resetn), .tick_us(tick_us), .record_en(record_en),
        .play_start(play_start), .key_state(key_state), .view_lo(view_lo), .view_hi(view_hi),
        .note_valid(note_valid), .note_ready(note_ready), .note_key(note_key),
        .note_start(note_start), .note_end(note_end), .frame_done(frame_done),
        .note_count(note_count), .overflow(overflow), .now_time(now_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          frame;
        int unsigned key;
        int unsigned st;
        int unsigned en;
    } exp_t;

    exp_t        q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned frames = 0;
    int unsigned tbTime = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expNote(input int unsigned k, input int unsigned s, input int unsigned e);
        q.push_back('{frame: 1'b0, key: k, st: s, en: e});
    endtask

    task automatic expFrame();
        q.push_back('{frame: 1'b1, key: 0, st: 0, en: 0});
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            if (q.size() == 0 || !q[0].frame) begin
                check("unexpectedFrameDone", 1, 0);
            end else begin
                checks++;
                void'(q.pop_front());
            end
            frames++;
        end
        if (note_valid) begin
            if (q.size() == 0 || q[0].frame) begin
                check("unexpectedNote", note_key, 99);
            end else begin
                check("noteKey", note_key, q[0].key);
                check("noteStart", note_start, q[0].st);
                check("noteEnd", note_end, q[0].en);
                if (note_ready) void'(q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (tick_us && tbTime < TMAX) tbTime++;
        #1;
    endtask

    task automatic runTo(input int unsigned t);
        tick_us = 1'b1;
        for (int i = 0; i < 200 && tbTime < t; i++) cyc();
    endtask

    task automatic keyAt(input int unsigned t, input int unsigned idx, input bit v);
        runTo(t);
        key_state[idx] = v;
        cyc();
    endtask

    task automatic startRec();
        tick_us = 1'b0;
        record_en = 1'b1;
        cyc();
        tbTime = 0;
        tick_us = 1'b1;
    endtask

    task automatic stopRec();
        tick_us = 1'b0;
        record_en = 1'b0;
        cyc();
        repeat (NK + 4) cyc();
    endtask

    task automatic play(input bit stall);
        int unsigned f0;
        int unsigned guard;
        f0 = frames;
        tick_us = 1'b0;
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        if (stall) begin
            guard = 0;
            while (!note_valid && guard < 50) begin
                cyc();
                guard++;
            end
            check("stallValidSeen", note_valid, 1);
            note_ready = 1'b0;
            repeat (5) cyc();
            note_ready = 1'b1;
        end
        guard = 0;
        while (frames == f0 && guard < 200) begin
            cyc();
            guard++;
        end
        check("framePulses", frames - f0, 1);
        cyc();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rstValid", note_valid, 0);
        check("rstCount", note_count, 0);
        check("rstOverflow", overflow, 0);
        check("rstNow", now_time, 0);
        check("rstFrame", frame_done, 0);
        check("rstKey", note_key, 0);
        resetn = 1'b1;
        cyc();

        // empty store: play gives only the frame pulse
        expFrame();
        play(0);

        // single note {3,10,25}, played twice to confirm the read pointer rewinds
        startRec();
        keyAt(10, 3, 1);
        keyAt(25, 3, 0);
        stopRec();
        check("t1Count", note_count, 1);
        expNote(3, 10, 25); expFrame();
        play(0);
        expNote(3, 10, 25); expFrame();
        play(0);

        // simultaneous presses of keys 0 and 5 within one tick
        startRec();
        runTo(4);
        tick_us = 1'b0;
        key_state[0] = 1'b1;
        key_state[5] = 1'b1;
        cyc();
        cyc();
        keyAt(8, 0, 0);
        keyAt(12, 5, 0);
        stopRec();
        check("t2Count", note_count, 2);
        expNote(0, 4, 8); expNote(5, 4, 12); expFrame();
        play(0);

        // overflow: five presses into a four-entry store
        startRec();
        keyAt(1, 1, 1);
        keyAt(2, 2, 1);
        keyAt(3, 3, 1);
        keyAt(4, 4, 1);
        keyAt(5, 6, 1);
        check("t3CountFull", note_count, 4);
        check("t3Overflow", overflow, 1);
        keyAt(6, 6, 0);
        keyAt(7, 2, 0);
        keyAt(8, 1, 0);
        keyAt(9, 4, 0);
        keyAt(10, 3, 0);
        stopRec();
        check("t3CountAfter", note_count, 4);
        expNote(1, 1, 8); expNote(2, 2, 7); expNote(3, 3, 10); expNote(4, 4, 9); expFrame();
        play(0);
        check("t3OverflowSticky", overflow, 1);

        // key 7 still held when recording stops: closed at 40
        startRec();
        keyAt(3, 7, 1);
        runTo(40);
        stopRec();
        check("t4Now", now_time, 40);
        check("t4Overflow", overflow, 0);
        key_state[7] = 1'b0;
        cyc();
        expNote(7, 3, 40); expFrame();
        play(0);

        // consumer stall of 5 cycles on the first note
        startRec();
        keyAt(2, 10, 1);
        keyAt(3, 11, 1);
        keyAt(4, 12, 1);
        keyAt(6, 10, 0);
        keyAt(7, 11, 0);
        keyAt(8, 12, 0);
        stopRec();
        expNote(10, 2, 6); expNote(11, 3, 7); expNote(12, 4, 8); expFrame();
        play(1);

        // window 10..40 over notes [5,9] and [20,30]
        startRec();
        keyAt(5, 1, 1);
        keyAt(9, 1, 0);
        keyAt(20, 2, 1);
        keyAt(30, 2, 0);
        stopRec();
        view_lo = 6'd10;
        view_hi = 6'd40;
`ifndef NOTE_REC_WINDOW_FILTER_EN
        expNote(1, 5, 9);
`endif
        expNote(2, 20, 30); expFrame();
        play(0);

        // timer saturates at all-ones
        startRec();
        repeat (70) cyc();
        check("timerSat", now_time, tbTime);
        check("timerSatMax", now_time, TMAX);
        stopRec();
        check("satCount", note_count, 0);
        expFrame();
        play(0);

        // asynchronous reset mid-recording
        startRec();
        keyAt(2, 4, 1);
        check("preRstCount", note_count, 1);
        resetn = 1'b0;
        #1;
        check("asyncRstCount", note_count, 0);
        check("asyncRstNow", now_time, 0);
        record_en = 1'b0;
        key_state = '0;
        cyc();
        resetn = 1'b1;
        cyc();
        expFrame();
        play(0);

        check("queueDrained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
